// File: rtl/pipeline_pkg.sv
// Shared pipeline types: opcode constants, ID/EX entry layout, load classifier.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   OP_LB..OP_LWR  load opcodes (contiguous range 32..38)
//   is_load()      load classifier, also used by the forwarding unit's write-after-mem check
//   state_t        issue-stage FSM states
//   id_ex_t        ID/EX pipeline register layout
//   BUBBLE         all-zero ID/EX entry (invalid, no write)
package pipeline_pkg;

   localparam int PKG_DATA_W = 32;
   localparam int PKG_REG_W  = 5;
   localparam int PKG_CNT_W  = 16;

   localparam logic [5:0] OP_LB  = 6'd32;
   localparam logic [5:0] OP_LH  = 6'd33;
   localparam logic [5:0] OP_LWL = 6'd34;
   localparam logic [5:0] OP_LW  = 6'd35;
   localparam logic [5:0] OP_LBU = 6'd36;
   localparam logic [5:0] OP_LHU = 6'd37;
   localparam logic [5:0] OP_LWR = 6'd38;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_BUBBLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   typedef struct packed {
      logic                  valid;
      logic [5:0]            op;
      logic [PKG_REG_W-1:0]  rd;
      logic                  register_write;
      logic [PKG_DATA_W-1:0] rs_val;
      logic [PKG_DATA_W-1:0] rt_val;
      logic [PKG_DATA_W-1:0] imm;
   } id_ex_t;

   localparam id_ex_t BUBBLE = '0;

   // Load opcodes are contiguous, so a range check covers the whole set.
   function automatic logic is_load(input logic [5:0] op);
      return (op >= OP_LB) && (op <= OP_LWR);
   endfunction

endpackage

// File: rtl/operand_issue_stage_if.sv
// Bundle of decode, forwarding, execute-feedback and ID/EX output signals.
// Latency: n/a (wiring only).
// Backpressure: ex_ready from execute; stall_cu back to PC/decode.
//
// Modports:
//   master  upstream/execute side: drives decode, forwarding and ex feedback, sees ID/EX + stall
//   slave   issue stage: consumes those inputs, drives stall_cu, ID/EX fields and stall_count
interface operand_issue_stage_if
   import pipeline_pkg::*;
#(
   parameter int DATA_W = PKG_DATA_W,
   parameter int REG_W  = PKG_REG_W,
   parameter int CNT_W  = PKG_CNT_W
);
   logic              valid_cu;
   logic [5:0]        op_cu;
   logic [REG_W-1:0]  rs_cu;
   logic [REG_W-1:0]  rt_cu;
   logic [REG_W-1:0]  rd_cu;
   logic              register_write_cu;
   logic [DATA_W-1:0] imm_cu;
   logic [DATA_W-1:0] rf_rs_data;
   logic [DATA_W-1:0] rf_rt_data;
   logic              forwarding_rs;
   logic              forwarding_rt;
   logic [DATA_W-1:0] value_rs;
   logic [DATA_W-1:0] value_rt;
   logic [5:0]        op_ex;
   logic [REG_W-1:0]  rd_ex;
   logic              register_write_ex;
   logic              ex_ready;
   logic              flush;
   logic              stall_cu;
   logic              valid_out;
   logic [5:0]        op_out;
   logic [REG_W-1:0]  rd_out;
   logic              register_write_out;
   logic [DATA_W-1:0] rs_val_out;
   logic [DATA_W-1:0] rt_val_out;
   logic [DATA_W-1:0] imm_out;
   logic [CNT_W-1:0]  stall_count;

   modport master (
      output valid_cu, op_cu, rs_cu, rt_cu, rd_cu, register_write_cu, imm_cu,
             rf_rs_data, rf_rt_data, forwarding_rs, forwarding_rt, value_rs, value_rt,
             op_ex, rd_ex, register_write_ex, ex_ready, flush,
      input  stall_cu, valid_out, op_out, rd_out, register_write_out,
             rs_val_out, rt_val_out, imm_out, stall_count
   );

   modport slave (
      input  valid_cu, op_cu, rs_cu, rt_cu, rd_cu, register_write_cu, imm_cu,
             rf_rs_data, rf_rt_data, forwarding_rs, forwarding_rt, value_rs, value_rt,
             op_ex, rd_ex, register_write_ex, ex_ready, flush,
      output stall_cu, valid_out, op_out, rd_out, register_write_out,
             rs_val_out, rt_val_out, imm_out, stall_count
   );
endinterface

// File: rtl/operand_issue_stage_hazard_detect.sv
// Load-use detection and issue FSM (RUN/BUBBLE/HOLD) deciding hold, bubble or capture.
// Latency: outputs combinational from inputs and current state.
// Backpressure: i_ex_ready=0 forces hold + stall; flush overrides everything.
//
// Ports: clk/rst; decode (i_valid_cu, i_rs_cu, i_rt_cu); execute (i_op_ex, i_rd_ex,
// i_register_write_ex, i_ex_ready); i_flush; o_stall, o_load_bubble, o_capture.
module hazard_detect
   import pipeline_pkg::*;
#(
   parameter int REG_W = PKG_REG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_valid_cu,
   input  logic [REG_W-1:0] i_rs_cu,
   input  logic [REG_W-1:0] i_rt_cu,
   input  logic [5:0]       i_op_ex,
   input  logic [REG_W-1:0] i_rd_ex,
   input  logic             i_register_write_ex,
   input  logic             i_ex_ready,
   input  logic             i_flush,
   output logic             o_stall,
   output logic             o_load_bubble,
   output logic             o_capture
);
   state_t r_state;
   state_t w_next_state;
   logic   w_load_use;
   logic   w_hazard;

   assign w_load_use = i_valid_cu && i_register_write_ex && is_load(i_op_ex) &&
                       (i_rd_ex != '0) && ((i_rd_ex == i_rs_cu) || (i_rd_ex == i_rt_cu));

   // In BUBBLE the load has moved to MEM and forwarding covers it, so the
   // hazard is masked to guarantee exactly one bubble per load-use pair.
   assign w_hazard = w_load_use && (r_state != ST_BUBBLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state  = ST_RUN;
      o_stall       = 1'b0;
      o_load_bubble = 1'b0;
      o_capture     = 1'b0;
      if (i_flush) begin
         o_load_bubble = 1'b1;
      end else if (!i_ex_ready) begin
         o_stall      = 1'b1;
         w_next_state = ST_HOLD;
      end else if (w_hazard) begin
         o_stall       = 1'b1;
         o_load_bubble = 1'b1;
         w_next_state  = ST_BUBBLE;
      end else begin
         o_capture = 1'b1;
      end
   end
endmodule

// File: rtl/operand_issue_stage.sv
// Decode-to-execute issue stage: operand select, load-use bubble insertion, ID/EX register.
// Latency: 1 cycle decode to ID/EX; 2 cycles when a load-use bubble is inserted.
// Backpressure: ex_ready=0 freezes ID/EX and raises stall_cu; flush loads a bubble.
//
// Ports: clk, rst (async, active high); bus (slave modport) carrying decode inputs,
// register-file reads, forwarding overrides, execute feedback, ID/EX outputs and stall_count.
module operand_issue_stage
   import pipeline_pkg::*;
#(
   parameter int DATA_W = PKG_DATA_W,
   parameter int REG_W  = PKG_REG_W,
   parameter int CNT_W  = PKG_CNT_W
) (
   input logic                  clk,
   input logic                  rst,
   operand_issue_stage_if.slave bus
);
   localparam logic [REG_W-1:0] ZERO_REG = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [DATA_W-1:0] w_rs_sel;
   logic [DATA_W-1:0] w_rt_sel;
   logic              w_stall;
   logic              w_load_bubble;
   logic              w_capture;
   id_ex_t            w_entry;
   id_ex_t            r_id_ex;
   logic [CNT_W-1:0]  r_stall_count;

   // Register 0 reads as zero unless the forwarding unit overrides it.
   assign w_rs_sel = bus.forwarding_rs ? bus.value_rs :
                     ((bus.rs_cu == ZERO_REG) ? '0 : bus.rf_rs_data);
   assign w_rt_sel = bus.forwarding_rt ? bus.value_rt :
                     ((bus.rt_cu == ZERO_REG) ? '0 : bus.rf_rt_data);

   hazard_detect #(
      .REG_W(REG_W)
   ) u_hazard (
      .clk                 (clk),
      .rst                 (rst),
      .i_valid_cu          (bus.valid_cu),
      .i_rs_cu             (bus.rs_cu),
      .i_rt_cu             (bus.rt_cu),
      .i_op_ex             (bus.op_ex),
      .i_rd_ex             (bus.rd_ex),
      .i_register_write_ex (bus.register_write_ex),
      .i_ex_ready          (bus.ex_ready),
      .i_flush             (bus.flush),
      .o_stall             (w_stall),
      .o_load_bubble       (w_load_bubble),
      .o_capture           (w_capture)
   );

   always_comb begin
      w_entry                = BUBBLE;
      w_entry.valid          = bus.valid_cu;
      w_entry.op             = bus.op_cu;
      w_entry.rd             = bus.rd_cu;
      w_entry.register_write = bus.register_write_cu & bus.valid_cu;
      w_entry.rs_val         = w_rs_sel;
      w_entry.rt_val         = w_rt_sel;
      w_entry.imm            = bus.imm_cu;
   end

   // Neither bubble nor capture means hold: ID/EX keeps its contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_id_ex <= BUBBLE;
      end else if (w_load_bubble) begin
         r_id_ex <= BUBBLE;
      end else if (w_capture) begin
         r_id_ex <= w_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_count <= '0;
      end else if (w_stall && (r_stall_count != '1)) begin
         r_stall_count <= r_stall_count + CNT_ONE;
      end
   end

   assign bus.stall_cu           = w_stall;
   assign bus.valid_out          = r_id_ex.valid;
   assign bus.op_out             = r_id_ex.op;
   assign bus.rd_out             = r_id_ex.rd;
   assign bus.register_write_out = r_id_ex.register_write;
   assign bus.rs_val_out         = r_id_ex.rs_val;
   assign bus.rt_val_out         = r_id_ex.rt_val;
   assign bus.imm_out            = r_id_ex.imm;
   assign bus.stall_count        = r_stall_count;
endmodule

// File: tb/tb_operand_issue_stage.sv
// Directed bench for operand_issue_stage: operand select, load-use bubble, hold, flush, reset.
// Latency: checks registered outputs 1 time unit after the rising edge.
// Backpressure: drives ex_ready low for a 3-cycle hold window.
module tb_operand_issue_stage;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   operand_issue_stage_if bus ();

   operand_issue_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.valid_cu = 0; bus.op_cu = 0; bus.rs_cu = 0; bus.rt_cu = 0; bus.rd_cu = 0;
      bus.register_write_cu = 0; bus.imm_cu = 0; bus.rf_rs_data = 0; bus.rf_rt_data = 0;
      bus.forwarding_rs = 0; bus.forwarding_rt = 0; bus.value_rs = 0; bus.value_rt = 0;
      bus.op_ex = 0; bus.rd_ex = 0; bus.register_write_ex = 0; bus.ex_ready = 1; bus.flush = 0;

      // Reset state
      #3;
      chk("rst_valid", 32'(bus.valid_out), 32'd0);
      chk("rst_rs_val", bus.rs_val_out, 32'd0);
      chk("rst_wr", 32'(bus.register_write_out), 32'd0);
      chk("rst_cnt", 32'(bus.stall_count), 32'd0);
      #9;
      rst = 1'b0;

      // add r3,r1,r2 with rf reads 5/7
      bus.valid_cu = 1; bus.op_cu = 6'd0; bus.rs_cu = 5'd1; bus.rt_cu = 5'd2; bus.rd_cu = 5'd3;
      bus.register_write_cu = 1; bus.imm_cu = 32'h10; bus.rf_rs_data = 32'd5; bus.rf_rt_data = 32'd7;
      #1;
      chk("add_stall", 32'(bus.stall_cu), 32'd0);
      tick();
      chk("add_valid", 32'(bus.valid_out), 32'd1);
      chk("add_rs", bus.rs_val_out, 32'd5);
      chk("add_rt", bus.rt_val_out, 32'd7);
      chk("add_rd", 32'(bus.rd_out), 32'd3);
      chk("add_wr", 32'(bus.register_write_out), 32'd1);
      chk("add_imm", bus.imm_out, 32'h10);

      // Forwarded rs overrides the register file
      bus.forwarding_rs = 1; bus.value_rs = 32'hDEADBEEF; bus.rf_rs_data = 32'd1;
      tick();
      chk("fwd_rs", bus.rs_val_out, 32'hDEADBEEF);
      chk("fwd_rt", bus.rt_val_out, 32'd7);

      // rs = r0 reads as zero
      bus.forwarding_rs = 0; bus.rs_cu = 5'd0; bus.rf_rs_data = 32'd9;
      tick();
      chk("r0_rs", bus.rs_val_out, 32'd0);

      // Load-use: lw r4 in execute, decode reads r4
      bus.op_ex = 6'd35; bus.rd_ex = 5'd4; bus.register_write_ex = 1;
      bus.rs_cu = 5'd4; bus.rf_rs_data = 32'd11;
      #1;
      chk("lu_stall", 32'(bus.stall_cu), 32'd1);
      tick();
      chk("lu_bubble_valid", 32'(bus.valid_out), 32'd0);
      chk("lu_bubble_wr", 32'(bus.register_write_out), 32'd0);
      chk("lu_cnt", 32'(bus.stall_count), 32'd1);
      chk("lu_masked_stall", 32'(bus.stall_cu), 32'd0);
      bus.forwarding_rs = 1; bus.value_rs = 32'h44;
      tick();
      chk("lu_issue_valid", 32'(bus.valid_out), 32'd1);
      chk("lu_issue_rs", bus.rs_val_out, 32'h44);
      chk("lu_issue_rd", 32'(bus.rd_out), 32'd3);
      chk("lu_cnt_after", 32'(bus.stall_count), 32'd1);
      bus.forwarding_rs = 0; bus.value_rs = 0;

      // lw with rd_ex=0 never stalls, even when rs_cu=0 matches
      bus.rd_ex = 5'd0; bus.rs_cu = 5'd0; bus.rf_rs_data = 32'd9;
      #1;
      chk("rd0_stall", 32'(bus.stall_cu), 32'd0);
      tick();
      chk("rd0_valid", 32'(bus.valid_out), 32'd1);
      chk("rd0_rs", bus.rs_val_out, 32'd0);

      // Load-set boundaries (combinational only, no edge taken)
      bus.rd_ex = 5'd4; bus.rs_cu = 5'd1; bus.rt_cu = 5'd4;
      bus.op_ex = 6'd38; #1; chk("op38_stall", 32'(bus.stall_cu), 32'd1);
      bus.op_ex = 6'd39; #1; chk("op39_stall", 32'(bus.stall_cu), 32'd0);
      bus.op_ex = 6'd32; #1; chk("op32_stall", 32'(bus.stall_cu), 32'd1);
      bus.op_ex = 6'd31; #1; chk("op31_stall", 32'(bus.stall_cu), 32'd0);
      bus.op_ex = 6'd35; bus.valid_cu = 0; #1; chk("novalid_stall", 32'(bus.stall_cu), 32'd0);
      bus.valid_cu = 1; bus.register_write_ex = 0; #1; chk("nowr_stall", 32'(bus.stall_cu), 32'd0);

      // sw in execute: no stall
      bus.op_ex = 6'd43; bus.register_write_ex = 1; bus.rs_cu = 5'd4; bus.rt_cu = 5'd2;
      bus.rf_rs_data = 32'd11;
      #1;
      chk("sw_stall", 32'(bus.stall_cu), 32'd0);
      tick();
      chk("sw_valid", 32'(bus.valid_out), 32'd1);
      chk("sw_rs", bus.rs_val_out, 32'd11);
      chk("sw_cnt", 32'(bus.stall_count), 32'd1);
      bus.op_ex = 0; bus.rd_ex = 0; bus.register_write_ex = 0;

      // Execute backpressure for 3 cycles
      bus.ex_ready = 0; bus.rd_cu = 5'd6; bus.rs_cu = 5'd1;
      for (int i = 0; i < 3; i++) begin
         bus.rf_rs_data = 32'h60 + 32'(i);
         #1;
         chk("hold_stall", 32'(bus.stall_cu), 32'd1);
         tick();
         chk("hold_rd", 32'(bus.rd_out), 32'd3);
         chk("hold_rs", bus.rs_val_out, 32'd11);
         chk("hold_cnt", 32'(bus.stall_count), 32'(2 + i));
      end
      bus.ex_ready = 1; bus.rf_rs_data = 32'h77;
      #1;
      chk("release_stall", 32'(bus.stall_cu), 32'd0);
      tick();
      chk("release_rs", bus.rs_val_out, 32'h77);
      chk("release_rd", 32'(bus.rd_out), 32'd6);
      chk("release_cnt", 32'(bus.stall_count), 32'd4);

      // Flush beats both backpressure and load-use
      bus.op_ex = 6'd35; bus.rd_ex = 5'd4; bus.register_write_ex = 1; bus.rs_cu = 5'd4;
      bus.ex_ready = 0; bus.flush = 1;
      #1;
      chk("flush_stall", 32'(bus.stall_cu), 32'd0);
      tick();
      chk("flush_valid", 32'(bus.valid_out), 32'd0);
      chk("flush_op", 32'(bus.op_out), 32'd0);
      chk("flush_rd", 32'(bus.rd_out), 32'd0);
      chk("flush_rs", bus.rs_val_out, 32'd0);
      chk("flush_cnt", 32'(bus.stall_count), 32'd4);
      // State is RUN: the still-present hazard stalls again
      bus.flush = 0; bus.ex_ready = 1;
      #1;
      chk("post_flush_stall", 32'(bus.stall_cu), 32'd1);
      tick();
      chk("bubble2_valid", 32'(bus.valid_out), 32'd0);
      chk("bubble2_cnt", 32'(bus.stall_count), 32'd5);
      chk("bubble2_masked", 32'(bus.stall_cu), 32'd0);

      // Async reset pulse while in BUBBLE
      #1 rst = 1'b1;
      #1;
      chk("arst_cnt", 32'(bus.stall_count), 32'd0);
      chk("arst_valid", 32'(bus.valid_out), 32'd0);
      chk("arst_rs", bus.rs_val_out, 32'd0);
      rst = 1'b0;
      #1;
      chk("arst_state_run", 32'(bus.stall_cu), 32'd1);
      bus.op_ex = 0; bus.rd_ex = 0; bus.register_write_ex = 0;
      tick();
      chk("final_valid", 32'(bus.valid_out), 32'd1);
      chk("final_rd", 32'(bus.rd_out), 32'd6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
